// File: rtl/load_ctr_pkg.sv
// Shared types and helpers for the load-value counter family.
// Mode encodings and terminal-value selection used by the step logic.
package load_ctr_pkg;

  typedef enum logic [1:0] {
    CTR_FREE    = 2'd0,
    CTR_MODULO  = 2'd1,
    CTR_ONESHOT = 2'd2
  } ctr_mode_e;

  localparam int CTR_MAX_W = 32;

  // MODULO and ONESHOT share the 0..Limit range; the reserved encoding acts as FREE.
  function automatic logic is_bounded(input logic [1:0] mode);
    return (mode == CTR_MODULO) || (mode == CTR_ONESHOT);
  endfunction

  // Value at which a step is terminal, evaluated in a 32-bit domain so one
  // function serves every legal counter width.
  function automatic logic [CTR_MAX_W-1:0] terminal_val(
    input logic [1:0]           mode,
    input logic                 up,
    input logic [CTR_MAX_W-1:0] limit,
    input int                   width
  );
    logic [CTR_MAX_W-1:0] all_ones;
    all_ones = (32'd1 << width) - 32'd1;
    if (!up)
      return '0;
    else if (is_bounded(mode))
      return limit;
    else
      return all_ones;
  endfunction

endpackage

// File: rtl/load_ctr_step.sv
// Combinational next-step value and terminal flag for the load-value counter.
// Pure function of the current count, direction, mode and limit.
module load_ctr_step
  import load_ctr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next_val,
  output logic             term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic bounded;

  assign bounded = is_bounded(mode);
  assign term    = (32'(count) == terminal_val(mode, up_dn, 32'(limit), WIDTH));

  // A count above Limit never matches the terminal value, so it keeps rising
  // until the natural binary wrap brings it back inside the range.
  always_comb begin
    next_val = count;
    if (up_dn) begin
      if (term)
        next_val = '0;
      else
        next_val = count + ONE;
    end else begin
      if (count == '0)
        next_val = bounded ? limit : '1;
      else
        next_val = count - ONE;
    end
  end

endmodule

// File: rtl/load_val_counter_gen.sv
// Programmable up/down counter with FREE/MODULO/ONESHOT modes and a load
// handshake whose loads apply immediately or at the next terminal count.
module load_val_counter_gen
  import load_ctr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             En,
  input  logic             Up_Dn,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Limit,
  input  logic             Load_Valid,
  input  logic             Load_Imm,
  input  logic [WIDTH-1:0] Load_Value,
  output logic             Load_Ready,
  output logic             Pending,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic             Done
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  logic             term;
  logic             accept;
  logic             tc;

  load_ctr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count    (count_q),
    .up_dn    (Up_Dn),
    .mode     (Mode),
    .limit    (Limit),
    .next_val (step_val),
    .term     (term)
  );

  // Tc is gated by reset so a terminal reset value cannot strobe while held.
  assign tc         = Rst_l & En & term & ~done_q;
  assign accept     = Load_Valid & ~pending_q;

  assign Tc         = tc;
  assign Load_Ready = ~pending_q;
  assign Pending    = pending_q;
  assign Count      = count_q;
  assign Done       = done_q;

  // Latching a deferred load does not stall counting; only the Tc that
  // consumes it replaces the wrap.
  always_comb begin
    count_d   = count_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    done_d    = done_q;
    if (accept && Load_Imm) begin
      count_d = Load_Value;
      done_d  = 1'b0;
    end else if (tc && (pending_q || accept)) begin
      count_d   = pending_q ? shadow_q : Load_Value;
      pending_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      if (accept) begin
        shadow_d  = Load_Value;
        pending_d = 1'b1;
      end
      if (tc && (Mode == CTR_ONESHOT))
        done_d = 1'b1;
      else if (En && !done_q)
        count_d = step_val;
    end
  end

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      count_q   <= RST_VAL;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

endmodule
